// File: rtl/lzc_pipe.sv
// Pipelined leading-zero/one counter: pair-encode stage, one registered combine level per stage.
// Optional LZC_PIPE_TRAILING_EN adds in_trailing_i to count trailing zeros/ones instead.
module lzc_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned LAT  = $clog2(WIDTH) + 1,
  localparam int unsigned CW   = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_ones_i,
`ifdef LZC_PIPE_TRAILING_EN
  input  logic             in_trailing_i,
`endif
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    out_count_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic                      adv;
  logic [LAT-1:0]            valid_q;
  logic [LAT-1:0][TAG_W-1:0] tag_q;
  logic [WIDTH-1:0]          word;
  logic [WIDTH-1:0]          s0_d, s0_q;
  logic [CW-1:0]             cnt_q;

  // Whole pipe moves as one; a held output freezes every stage.
  assign adv        = ~valid_q[LAT-1] | out_ready_i;
  assign in_ready_o = adv;

  always_comb begin
    word = in_data_i;
`ifdef LZC_PIPE_TRAILING_EN
    if (in_trailing_i) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        word[i] = in_data_i[int'(WIDTH) - 1 - i];
      end
    end
`endif
    word = word ^ {WIDTH{in_ones_i}};
    s0_d = '0;
    // 2-bit code per pair: 00->10, 01->01, 1x->00
    for (int j = 0; j < int'(WIDTH / 2); j++) begin
      s0_d[2*j+1] = ~word[2*j+1] & ~word[2*j];
      s0_d[2*j]   = ~word[2*j+1] &  word[2*j];
    end
  end

  for (genvar l = 1; l <= int'(LAT) - 2; l++) begin : g_lvl
    localparam int unsigned N    = l + 1;
    localparam int unsigned NOUT = WIDTH >> (l + 1);

    logic [2*NOUT*N-1:0]     prev;
    logic [NOUT*(N+1)-1:0]   lvl_d, lvl_q;

    if (l == 1) begin : g_first
      assign prev = s0_q;
    end else begin : g_rest
      assign prev = g_lvl[l-1].lvl_q;
    end

    for (genvar j = 0; j < int'(NOUT); j++) begin : g_node
      logic [N-1:0] hi, lo;
      assign hi = prev[(2*j+1)*N +: N];
      assign lo = prev[2*j*N +: N];
      assign lvl_d[j*(N+1) +: N+1] = hi[N-1] ? {hi[N-1] & lo[N-1], ~lo[N-1], lo[N-2:0]}
                                             : {1'b0, hi};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lvl_q <= '0;
      end else if (adv) begin
        lvl_q <= lvl_d;
      end
    end
  end

  // Last stage only re-registers the finished code to keep the depth at LAT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      tag_q   <= '0;
      s0_q    <= '0;
      cnt_q   <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[LAT-2:0], in_valid_i};
      tag_q   <= {tag_q[LAT-2:0], in_tag_i};
      s0_q    <= s0_d;
      cnt_q   <= g_lvl[LAT-2].lvl_q;
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_count_o = valid_q[LAT-1] ? cnt_q : '0;
  assign out_tag_o   = valid_q[LAT-1] ? tag_q[LAT-1] : '0;

endmodule

// File: tb/tb_lzc_pipe.sv
// Scoreboard bench for lzc_pipe (WIDTH=32): recorder pushes model results on accept,
// monitor pops and compares on every output transfer.
module tb_lzc_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned LAT   = 6;
  localparam int unsigned CW    = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ones = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    out_count;
  logic [TAG_W-1:0] out_tag;
`ifdef LZC_PIPE_TRAILING_EN
  logic             in_trailing = 1'b0;
`endif

  lzc_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_ones_i    (in_ones),
`ifdef LZC_PIPE_TRAILING_EN
    .in_trailing_i(in_trailing),
`endif
    .in_tag_i     (in_tag),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_count_o  (out_count),
    .out_tag_o    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int tag;
    int t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   received = 0;
  int   pushed = 0;
  bit   lat_chk = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_cnt = 0;
  int   prev_tag = 0;

  always @(posedge clk) cyc++;

  // Reference: scan from the MSB while bits equal the counted value.
  function automatic int ref_count(logic [WIDTH-1:0] d, logic ones);
    int  n = 0;
    bit  run = 1'b1;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (run && d[i] == ones) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Recorder
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back('{ref_count(in_data, in_ones), int'(in_tag), cyc});
      pushed++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      if (prev_stall && out_valid) begin
        check("stall_count_stable", int'(out_count), prev_cnt);
        check("stall_tag_stable", int'(out_tag), prev_tag);
      end
      prev_stall = out_valid && !out_ready;
      prev_cnt   = int'(out_count);
      prev_tag   = int'(out_tag);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got count %0d tag %0d expected none", out_count,
                   out_tag);
        end else begin
          e = sb.pop_front();
          check("out_count", int'(out_count), e.cnt);
          check("out_tag", int'(out_tag), e.tag);
          if (lat_chk) check("latency", cyc - e.t, int'(LAT));
        end
        received++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit ones,
                       input logic [TAG_W-1:0] tag);
    @(posedge clk);
    #2;
    in_valid = v;
    in_data  = d;
    in_ones  = ones;
    in_tag   = tag;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  logic [WIDTH-1:0] dir_data [7] = '{32'h8000_0000, 32'h0001_0000, 32'h0000_0001,
                                     32'h0000_0000, 32'hFFFF_FFFF, 32'hF7FF_FFFF,
                                     32'h7FFF_FFFF};
  bit               dir_ones [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int r0;
    int p0;

    // Reset held with in_valid asserted
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_count", int'(out_count), 0);
      check("rst_out_tag", int'(out_tag), 0);
    end
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", int'(in_ready), 1);

    // Directed single words, exact latency
    lat_chk = 1'b1;
    for (int i = 0; i < 7; i++) begin
      r0 = received;
      drive(1'b1, dir_data[i], dir_ones[i], TAG_W'(i + 3));
      drive(1'b0, '0, 1'b0, '0);
      wait_drain("directed", 40);
      check("directed_one_output", received - r0, 1);
    end
    lat_chk = 1'b0;

    // Back-to-back streaming
    r0 = received;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, $urandom >> $urandom_range(0, 32), 1'($urandom_range(0, 1)),
            TAG_W'($urandom));
    end
    drive(1'b0, '0, 1'b0, '0);
    wait_drain("stream", 40);
    check("stream_count", received - r0, 64);

    // Random backpressure
    r0 = received;
    p0 = pushed;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 32),
            1'($urandom_range(0, 1)), TAG_W'($urandom));
      out_ready = ($urandom_range(0, 99) < 30);
    end
    drive(1'b0, '0, 1'b0, '0);
    out_ready = 1'b1;
    wait_drain("backpressure", 100);
    check("bp_no_drop_dup", received - r0, pushed - p0);

    // Reset with words in flight
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0000_1000 << i, 1'b0, TAG_W'(i));
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    r0    = received;
    repeat (10) @(negedge clk);
    check("rst_flushed", received - r0, 0);
    lat_chk = 1'b1;
    drive(1'b1, 32'h0000_00FF, 1'b0, 4'h5);
    drive(1'b0, '0, 1'b0, '0);
    wait_drain("post_rst", 40);
    check("post_rst_first", received - r0, 1);
    lat_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
